axi_io_pmp_err_slv: RTL and testbench

Error-completion stage that sits directly downstream of the IO-PMP check on its deny path. Every AXI transaction the PMP rejects is routed here instead of to memory. The block completes it protocol-correctly: it absorbs all write data beats, answers each write with a single error B response, and answers each read with exactly arlen+1 error R beats. It also keeps a saturating count of completed denied transactions for software status.

---
 rtl/axi_io_pmp_err_slv.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_io_pmp_err_slv.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_io_pmp_err_slv.sv
// -----------------------------------------------------------------------------
// axi_io_pmp_err_slv
//
// Error-completion slave on the deny path of the IO-PMP. Every transaction the
// PMP rejects lands here and is completed protocol-correctly:
//   - writes: AW is accepted, all W beats are drained, one error B is returned;
//   - reads : AR is accepted, exactly arlen+1 error R beats are returned.
// The write and read paths are independent, each with one transaction in
// flight. A saturating counter tracks completed denied transactions.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   s_axi_aw*             write address channel (id, len, valid/ready)
//   s_axi_w*              write data channel (only wlast and valid/ready used)
//   s_axi_b*              write response channel (id, resp, valid/ready)
//   s_axi_ar*             read address channel (id, len, valid/ready)
//   s_axi_r*              read data channel (id, data, resp, last, valid/ready)
//   cnt_denied            saturating count of completed denied transactions
//   proto_err             one-cycle pulse when W beat count disagrees with awlen
// -----------------------------------------------------------------------------
module axi_io_pmp_err_slv #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 8,
    parameter logic [1:0]            ERR_RESP   = 2'b10,
    parameter logic [DATA_WIDTH-1:0] RDATA_FILL = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // write address
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [7:0]            s_axi_awlen,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    // write data
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    // write response
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    // read address
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [7:0]            s_axi_arlen,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    // read data
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    // status
    output logic [CNT_WIDTH-1:0]  cnt_denied,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_DRAIN = 2'd1,
        W_RESP  = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } r_state_t;

    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;

    // Held low through reset and for the first edge after it, so that neither
    // address channel reports ready while rst_n is asserted.
    logic                  run_q;

    logic [ID_WIDTH-1:0]   awid_q;
    logic [7:0]            awlen_q;
    logic [8:0]            beat_cnt;
    logic                  proto_err_q;

    logic [ID_WIDTH-1:0]   arid_q;
    logic [8:0]            remaining;

    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, r_done;

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid  & s_axi_wready;
    assign b_hs   = s_axi_bvalid  & s_axi_bready;
    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign r_hs   = s_axi_rvalid  & s_axi_rready;
    assign r_done = r_hs & s_axi_rlast;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            run_q   <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // -------------------------------------------------------------------------
    // Write FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                s_axi_awready = run_q;
                if (s_axi_awvalid && run_q) w_next = W_DRAIN;
            end
            W_DRAIN: begin
                // W is only accepted here, so early W data stalls until AW.
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && s_axi_wlast) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Read FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                s_axi_arready = run_q;
                if (s_axi_arvalid && run_q) r_next = R_BURST;
            end
            R_BURST: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = (remaining == 9'd0);
                if (s_axi_rready && s_axi_rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Write datapath: latched ID/length, beat counter, length check
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awid_q      <= '0;
            awlen_q     <= '0;
            beat_cnt    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            // (beat_cnt + 1) != (awlen + 1) reduces to beat_cnt != awlen.
            proto_err_q <= w_hs && s_axi_wlast && (beat_cnt != {1'b0, awlen_q});
            if (aw_hs) begin
                awid_q   <= s_axi_awid;
                awlen_q  <= s_axi_awlen;
                beat_cnt <= '0;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + 9'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read datapath: latched ID, remaining-beat count
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arid_q    <= '0;
            remaining <= '0;
        end else if (ar_hs) begin
            arid_q    <= s_axi_arid;
            remaining <= {1'b0, s_axi_arlen};
        end else if (r_hs && !s_axi_rlast) begin
            remaining <= remaining - 9'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating denied-transaction counter (+0, +1 or +2 per cycle)
    // -------------------------------------------------------------------------
    logic [1:0]           cnt_inc;
    logic [CNT_WIDTH:0]   cnt_sum;

    assign cnt_inc = {1'b0, b_hs} + {1'b0, r_done};
    assign cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(cnt_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_sum[CNT_WIDTH]) begin
            cnt_q <= '1;
        end else begin
            cnt_q <= cnt_sum[CNT_WIDTH-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Payload outputs: driven from registers only, hence stable under stall
    // -------------------------------------------------------------------------
    assign s_axi_bid   = awid_q;
    assign s_axi_bresp = s_axi_bvalid ? ERR_RESP : 2'b00;
    assign s_axi_rid   = arid_q;
    assign s_axi_rresp = s_axi_rvalid ? ERR_RESP : 2'b00;
    assign s_axi_rdata = RDATA_FILL;
    assign cnt_denied  = cnt_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_axi_io_pmp_err_slv.sv
// -----------------------------------------------------------------------------
// tb_axi_io_pmp_err_slv
//
// Directed bench for axi_io_pmp_err_slv. The counter is narrowed to 4 bits so
// the saturation corner is reachable with a handful of transactions.
// -----------------------------------------------------------------------------
module tb_axi_io_pmp_err_slv;

    localparam int          DW   = 32;
    localparam int          IW   = 8;
    localparam int          CW   = 4;
    localparam logic [DW-1:0] FILL = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] s_axi_awid = '0;
    logic [7:0]    s_axi_awlen = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic          s_axi_wlast = 1'b0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b0;
    logic [IW-1:0] s_axi_arid = '0;
    logic [7:0]    s_axi_arlen = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b0;
    logic [CW-1:0] cnt_denied;
    logic          proto_err;

    int errors = 0;
    int checks = 0;
    int proto_pulses = 0;

    axi_io_pmp_err_slv #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .ERR_RESP   (2'b10),
        .RDATA_FILL (FILL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .cnt_denied    (cnt_denied),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    // Number of cycles proto_err was seen high.
    always @(posedge clk) begin
        if (proto_err) proto_pulses <= proto_pulses + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [IW-1:0] id, input logic [7:0] len);
        s_axi_awid    = id;
        s_axi_awlen   = len;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 20 && !s_axi_awready; i++) tick();
        check("aw_ready", s_axi_awready, 1'b1);
        tick();
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wlast  = (b == nbeats - 1);
            for (int i = 0; i < 20 && !s_axi_wready; i++) tick();
            check("w_ready", s_axi_wready, 1'b1);
            tick();
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
    endtask

    // Wait for B, hold bready low for hold_cycles while checking the payload
    // does not move, then accept it.
    task automatic take_b(input logic [IW-1:0] id, input int hold_cycles);
        for (int i = 0; i < 20 && !s_axi_bvalid; i++) tick();
        check("b_valid", s_axi_bvalid, 1'b1);
        for (int i = 0; i < hold_cycles; i++) begin
            tick();
            check("b_hold_valid", s_axi_bvalid, 1'b1);
            check("b_hold_id", s_axi_bid, id);
            check("b_hold_resp", s_axi_bresp, 2'b10);
        end
        check("b_id", s_axi_bid, id);
        check("b_resp", s_axi_bresp, 2'b10);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("b_single", s_axi_bvalid, 1'b0);
    endtask

    task automatic do_write(input logic [IW-1:0] id, input logic [7:0] len,
                            input int nbeats, input int hold_cycles);
        send_aw(id, len);
        send_w(nbeats);
        take_b(id, hold_cycles);
    endtask

    // Issue AR and receive the burst. With toggle set, rready alternates 0/1
    // starting at 0, and every stalled beat must hold its payload.
    task automatic do_read(input logic [IW-1:0] id, input logic [7:0] len, input bit toggle);
        int            beat;
        int            cyc;
        bit            stalled;
        logic [IW-1:0] prev_id;
        logic          prev_last;
        beat    = 0;
        cyc     = 0;
        stalled = 0;
        prev_id   = '0;
        prev_last = 1'b0;
        s_axi_arid    = id;
        s_axi_arlen   = len;
        s_axi_arvalid = 1'b1;
        for (int i = 0; i < 20 && !s_axi_arready; i++) tick();
        check("ar_ready", s_axi_arready, 1'b1);
        tick();
        s_axi_arvalid = 1'b0;
        check("r_first_valid", s_axi_rvalid, 1'b1);
        while (beat <= int'(len) && cyc < 600) begin
            s_axi_rready = toggle ? cyc[0] : 1'b1;
            if (!toggle) check("r_b2b", s_axi_rvalid, 1'b1);
            if (stalled) begin
                check("r_hold_valid", s_axi_rvalid, 1'b1);
                check("r_hold_id", s_axi_rid, prev_id);
                check("r_hold_last", s_axi_rlast, prev_last);
            end
            if (s_axi_rvalid) begin
                check("ar_busy", s_axi_arready, 1'b0);
                if (s_axi_rready) begin
                    check("r_id", s_axi_rid, id);
                    check("r_resp", s_axi_rresp, 2'b10);
                    check("r_data", s_axi_rdata, FILL);
                    check("r_last", s_axi_rlast, (beat == int'(len)));
                    beat++;
                    stalled = 0;
                end else begin
                    stalled   = 1;
                    prev_id   = s_axi_rid;
                    prev_last = s_axi_rlast;
                end
            end
            tick();
            cyc++;
        end
        s_axi_rready = 1'b0;
        check("r_beats", beat, int'(len) + 1);
        if (!toggle) check("r_cycles", cyc, int'(len) + 1);
        check("r_done", s_axi_rvalid, 1'b0);
    endtask

    initial begin
        int pulses0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", s_axi_awready, 1'b0);
        check("rst_arready", s_axi_arready, 1'b0);
        check("rst_wready", s_axi_wready, 1'b0);
        check("rst_bvalid", s_axi_bvalid, 1'b0);
        check("rst_rvalid", s_axi_rvalid, 1'b0);
        check("rst_rlast", s_axi_rlast, 1'b0);
        check("rst_proto", proto_err, 1'b0);
        check("rst_cnt", cnt_denied, 4'd0);
        check("rst_bid", s_axi_bid, 8'h00);
        check("rst_rid", s_axi_rid, 8'h00);
        check("rst_bresp", s_axi_bresp, 2'b00);
        check("rst_rresp", s_axi_rresp, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("run_awready", s_axi_awready, 1'b1);
        check("run_arready", s_axi_arready, 1'b1);

        // ---- single write ----
        pulses0 = proto_pulses;
        do_write(8'h5A, 8'd0, 1, 0);
        check("wr1_cnt", cnt_denied, 4'd1);
        check("wr1_proto", proto_pulses - pulses0, 0);

        // ---- read burst, rready held high ----
        do_read(8'h03, 8'd3, 1'b0);
        check("rd1_cnt", cnt_denied, 4'd2);

        // ---- backpressure on B and R ----
        do_write(8'hC4, 8'd1, 2, 5);
        check("bp_w_cnt", cnt_denied, 4'd3);
        do_read(8'h77, 8'd1, 1'b1);
        check("bp_r_cnt", cnt_denied, 4'd4);

        // ---- early W, then length mismatch (len=3, wlast on beat 2) ----
        pulses0 = proto_pulses;
        s_axi_wvalid = 1'b1;
        s_axi_wlast  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("early_w_stall", s_axi_wready, 1'b0);
        end
        send_aw(8'h21, 8'd3);
        check("early_w_open", s_axi_wready, 1'b1);
        send_w(2);
        take_b(8'h21, 0);
        tick();
        check("mis_proto_once", proto_pulses - pulses0, 1);
        check("mis_cnt", cnt_denied, 4'd5);

        // ---- reset during beat 2 of a 4-beat read ----
        s_axi_arid    = 8'h44;
        s_axi_arlen   = 8'd3;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        check("mid_beat1", s_axi_rvalid, 1'b1);
        tick();
        check("mid_beat2", s_axi_rvalid, 1'b1);
        check("mid_beat2_last", s_axi_rlast, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rvalid_drop", s_axi_rvalid, 1'b0);
        check("mid_rlast_drop", s_axi_rlast, 1'b0);
        check("mid_arready", s_axi_arready, 1'b0);
        check("mid_cnt", cnt_denied, 4'd0);
        s_axi_rready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_arready", s_axi_arready, 1'b1);
        do_read(8'h45, 8'd1, 1'b0);
        check("post_cnt", cnt_denied, 4'd1);

        // ---- fill counter to 4'hE ----
        for (int k = 0; k < 13; k++) do_write(IW'(k + 16), 8'd0, 1, 0);
        check("fill_cnt", cnt_denied, 4'hE);

        // ---- simultaneous B and final R at 4'hE -> saturates at 4'hF ----
        s_axi_awid    = 8'hB1;
        s_axi_awlen   = 8'd0;
        s_axi_awvalid = 1'b1;
        s_axi_arid    = 8'hA1;
        s_axi_arlen   = 8'd0;
        s_axi_arvalid = 1'b1;
        check("sim_awready", s_axi_awready, 1'b1);
        check("sim_arready", s_axi_arready, 1'b1);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_wvalid  = 1'b1;
        s_axi_wlast   = 1'b1;
        tick();
        s_axi_wvalid  = 1'b0;
        s_axi_wlast   = 1'b0;
        check("sim_bvalid", s_axi_bvalid, 1'b1);
        check("sim_rvalid", s_axi_rvalid, 1'b1);
        check("sim_rlast", s_axi_rlast, 1'b1);
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        check("sat_cnt", cnt_denied, 4'hF);
        do_write(8'hB2, 8'd0, 1, 0);
        check("sat_hold", cnt_denied, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
